// File: rtl/lb_arb_pkg.sv
// Shared definitions for the two-requester LocalBus arbiter.
//   lb_state_e            : arbiter sequencing states
//   LB_RD_ERR_DATA        : read data returned when no slave answers in time
//   LB_RD_TIMEOUT_DEFAULT : default number of cycles to wait for lb_rd_rdy
package lb_arb_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        WAIT = 3'd3,
        ACK  = 3'd4
    } lb_state_e;

    localparam logic [31:0] LB_RD_ERR_DATA        = 32'hDEAD_BEEF;
    localparam int unsigned LB_RD_TIMEOUT_DEFAULT = 255;

endpackage : lb_arb_pkg

// File: rtl/lb_arbiter.sv
// lb_arbiter: round-robin arbiter between two LocalBus requesters (m0 = host
// bridge, m1 = on-chip master) and the shared LocalBus slave fabric.
// Serialises single-beat reads/writes; every read completes, with an error
// completion (data DEAD_BEEF, mX_err=1) when no lb_rd_rdy arrives within
// RD_TIMEOUT cycles.
// Ports:
//   clk_lb, reset_n          : clock, asynchronous active-low reset
//   mX_req/wr/addr/wr_d      : request from requester X (held until mX_ack)
//   mX_ack/err/rd_d          : registered completion pulse, error flag, read data
//   lb_wr/lb_rd              : one-cycle strobes to the fabric
//   lb_addr/lb_wr_d          : address and write data to the fabric
//   lb_rd_d/lb_rd_rdy        : read data and its valid pulse from the fabric
module lb_arbiter
    import lb_arb_pkg::*;
#(
    parameter int unsigned RD_TIMEOUT = LB_RD_TIMEOUT_DEFAULT
) (
    input  logic        clk_lb,
    input  logic        reset_n,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wr_d,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rd_d,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wr_d,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rd_d,
    output logic        lb_wr,
    output logic        lb_rd,
    output logic [31:0] lb_addr,
    output logic [31:0] lb_wr_d,
    input  logic [31:0] lb_rd_d,
    input  logic        lb_rd_rdy
);

    // The counter starts at 0 in the first WAIT cycle, so the last WAIT cycle
    // of the window holds RD_TIMEOUT-1.
    localparam logic [15:0] TERM_CNT = 16'(RD_TIMEOUT - 1);

    lb_state_e   state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_stb_q, wr_stb_d;
    logic        rd_stb_q, rd_stb_d;
    logic [15:0] cnt_q, cnt_d;

    // Completion events for the currently granted requester.
    logic        ack_set;
    logic        err_set;
    logic        rd_load;
    logic [31:0] rd_val;

    logic [1:0]  req;
    logic        pick;
    logic        req_wr   [2];
    logic [31:0] req_addr [2];
    logic [31:0] req_data [2];

    logic        ack_q     [2];
    logic        ack_d     [2];
    logic        err_q     [2];
    logic        err_d     [2];
    logic [31:0] rd_data_q [2];
    logic [31:0] rd_data_d [2];

    assign req         = {m1_req, m0_req};
    assign req_wr[0]   = m0_wr;
    assign req_wr[1]   = m1_wr;
    assign req_addr[0] = m0_addr;
    assign req_addr[1] = m1_addr;
    assign req_data[0] = m0_wr_d;
    assign req_data[1] = m1_wr_d;

    // On a tie the requester that was not served last wins.
    assign pick = (req == 2'b11) ? ~last_grant_q : req[1];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_stb_d     = 1'b0;
        rd_stb_d     = 1'b0;
        cnt_d        = cnt_q;
        ack_set      = 1'b0;
        err_set      = 1'b0;
        rd_load      = 1'b0;
        rd_val       = lb_rd_d;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = pick;
                    addr_d  = req_addr[pick];
                    wdata_d = req_data[pick];
                    if (req_wr[pick]) begin
                        state_d  = WR;
                        wr_stb_d = 1'b1;
                    end else begin
                        state_d  = RD;
                        rd_stb_d = 1'b1;
                    end
                end
            end
            WR: begin
                state_d = ACK;
                ack_set = 1'b1;
            end
            RD: begin
                cnt_d = '0;
                if (lb_rd_rdy) begin
                    state_d = ACK;
                    ack_set = 1'b1;
                    rd_load = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 16'd1;
                // Data arriving on the terminal cycle still counts as a hit.
                if (lb_rd_rdy) begin
                    state_d = ACK;
                    ack_set = 1'b1;
                    rd_load = 1'b1;
                end else if (cnt_q == TERM_CNT) begin
                    state_d = ACK;
                    ack_set = 1'b1;
                    err_set = 1'b1;
                    rd_load = 1'b1;
                    rd_val  = LB_RD_ERR_DATA;
                end
            end
            ACK: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_lb or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_stb_q     <= 1'b0;
            rd_stb_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_stb_q     <= wr_stb_d;
            rd_stb_q     <= rd_stb_d;
            cnt_q        <= cnt_d;
        end
    end

    // Per-requester completion registers; only the granted side ever moves.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign ack_d[gi]     = ack_set && (grant_q == 1'(gi));
        assign err_d[gi]     = err_set && (grant_q == 1'(gi));
        assign rd_data_d[gi] = (rd_load && (grant_q == 1'(gi))) ? rd_val : rd_data_q[gi];

        always_ff @(posedge clk_lb or negedge reset_n) begin
            if (!reset_n) begin
                ack_q[gi]     <= 1'b0;
                err_q[gi]     <= 1'b0;
                rd_data_q[gi] <= '0;
            end else begin
                ack_q[gi]     <= ack_d[gi];
                err_q[gi]     <= err_d[gi];
                rd_data_q[gi] <= rd_data_d[gi];
            end
        end
    end

    assign m0_ack  = ack_q[0];
    assign m0_err  = err_q[0];
    assign m0_rd_d = rd_data_q[0];
    assign m1_ack  = ack_q[1];
    assign m1_err  = err_q[1];
    assign m1_rd_d = rd_data_q[1];
    assign lb_wr   = wr_stb_q;
    assign lb_rd   = rd_stb_q;
    assign lb_addr = addr_q;
    assign lb_wr_d = wdata_q;

endmodule : lb_arbiter

// File: tb/tb_lb_arbiter.sv
// Self-checking bench for lb_arbiter: scoreboard queues per requester are
// filled when a request is driven and drained when the matching ack appears.
module tb_lb_arbiter;

    localparam int          RDT      = 8;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    logic        clk_lb = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_req = 1'b0, m0_wr = 1'b0;
    logic [31:0] m0_addr = '0, m0_wr_d = '0;
    logic        m0_ack, m0_err;
    logic [31:0] m0_rd_d;
    logic        m1_req = 1'b0, m1_wr = 1'b0;
    logic [31:0] m1_addr = '0, m1_wr_d = '0;
    logic        m1_ack, m1_err;
    logic [31:0] m1_rd_d;
    logic        lb_wr, lb_rd;
    logic [31:0] lb_addr, lb_wr_d;
    logic [31:0] lb_rd_d = '0;
    logic        lb_rd_rdy = 1'b0;

    lb_arbiter #(.RD_TIMEOUT(RDT)) dut (
        .clk_lb    (clk_lb),
        .reset_n   (reset_n),
        .m0_req    (m0_req),
        .m0_wr     (m0_wr),
        .m0_addr   (m0_addr),
        .m0_wr_d   (m0_wr_d),
        .m0_ack    (m0_ack),
        .m0_err    (m0_err),
        .m0_rd_d   (m0_rd_d),
        .m1_req    (m1_req),
        .m1_wr     (m1_wr),
        .m1_addr   (m1_addr),
        .m1_wr_d   (m1_wr_d),
        .m1_ack    (m1_ack),
        .m1_err    (m1_err),
        .m1_rd_d   (m1_rd_d),
        .lb_wr     (lb_wr),
        .lb_rd     (lb_rd),
        .lb_addr   (lb_addr),
        .lb_wr_d   (lb_wr_d),
        .lb_rd_d   (lb_rd_d),
        .lb_rd_rdy (lb_rd_rdy)
    );

    always #5 clk_lb = ~clk_lb;

    int cyc = 0;
    always @(posedge clk_lb) cyc <= cyc + 1;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;      // ack cycle minus strobe cycle, -1 = unchecked
        int          req_cyc;
        int          slat;     // strobe cycle minus drive cycle, -1 = unchecked
    } exp_t;

    exp_t        sb0[$];
    exp_t        sb1[$];
    int          ack_log[$];
    int          ack_cnt[2] = '{0, 0};
    logic [31:0] model_rd[2] = '{32'h0, 32'h0};

    int checks = 0;
    int errors = 0;

    int          fab_delay = -1;
    logic [31:0] fab_data  = '0;
    int          stray_at  = -1;

    int          strobes = 0;
    int          strobe_cyc = 0;
    logic        strobe_wr = 1'b0;
    logic [31:0] strobe_addr = '0;
    logic [31:0] strobe_wdata = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Fabric model: answers lb_rd after fab_delay cycles (-1 = never), plus an
    // optional stray rdy pulse at cycle stray_at.
    initial begin
        int cnt;
        bit armed;
        cnt   = 0;
        armed = 1'b0;
        forever begin
            @(negedge clk_lb);
            lb_rd_rdy = 1'b0;
            if (!reset_n) begin
                armed = 1'b0;
            end else begin
                if (lb_rd) begin
                    armed = (fab_delay >= 0);
                    cnt   = fab_delay;
                end
                if (armed) begin
                    if (cnt == 0) begin
                        lb_rd_rdy = 1'b1;
                        lb_rd_d   = fab_data;
                        armed     = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                if (cyc == stray_at) begin
                    lb_rd_rdy = 1'b1;
                    lb_rd_d   = 32'h5757_5757;
                end
            end
        end
    end

    task automatic check_ack(input int id);
        exp_t        e;
        logic [31:0] rdd;
        logic        er;
        logic        other;
        rdd   = (id == 0) ? m0_rd_d : m1_rd_d;
        er    = (id == 0) ? m0_err  : m1_err;
        other = (id == 0) ? m1_ack  : m0_ack;
        ack_cnt[id]++;
        ack_log.push_back(id);
        $display("ack m%0d cyc=%0d addr=%h err=%0d rd_d=%h", id, cyc, lb_addr, er, rdd);
        if ((id == 0 && sb0.size() == 0) || (id == 1 && sb1.size() == 0)) begin
            chk("unexpected_ack", 32'd1, 32'd0);
            return;
        end
        e = (id == 0) ? sb0.pop_front() : sb1.pop_front();
        chk("strobe_count", strobes, 1);
        strobes = 0;
        chk("other_ack", other, 1'b0);
        chk("strobe_kind", strobe_wr, e.wr);
        chk("strobe_addr", strobe_addr, e.addr);
        chk("lb_addr_hold", lb_addr, e.addr);
        if (e.wr) chk("strobe_wdata", strobe_wdata, e.wdata);
        chk("ack_err", er, e.err);
        chk("ack_rd_d", rdd, e.rdata);
        if (e.lat >= 0) chk("ack_latency", cyc - strobe_cyc, e.lat);
        if (e.slat >= 0) chk("strobe_latency", strobe_cyc - e.req_cyc, e.slat);
    endtask

    // Monitor: records strobes, checks each ack against the scoreboard.
    initial begin
        forever begin
            @(negedge clk_lb);
            if (reset_n) begin
                if (lb_wr || lb_rd) begin
                    strobes++;
                    strobe_cyc   = cyc;
                    strobe_wr    = lb_wr;
                    strobe_addr  = lb_addr;
                    strobe_wdata = lb_wr_d;
                end
                if (m0_ack) check_ack(0);
                if (m1_ack) check_ack(1);
            end
        end
    end

    task automatic set_req(input int id, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        if (id == 0) begin
            m0_req = r; m0_wr = w; m0_addr = a; m0_wr_d = d;
        end else begin
            m1_req = r; m1_wr = w; m1_addr = a; m1_wr_d = d;
        end
    endtask

    task automatic push_exp(input int id, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input int slat);
        exp_t e;
        e.wr = w; e.addr = a; e.wdata = d; e.req_cyc = cyc; e.slat = slat;
        if (w) begin
            e.err = 1'b0; e.rdata = model_rd[id]; e.lat = 1;
        end else if (fab_delay >= 0 && fab_delay <= RDT) begin
            e.err = 1'b0; e.rdata = fab_data; e.lat = 1 + fab_delay;
        end else begin
            e.err = 1'b1; e.rdata = ERR_DATA; e.lat = 1 + RDT;
        end
        if (!w) model_rd[id] = e.rdata;
        if (id == 0) sb0.push_back(e);
        else         sb1.push_back(e);
    endtask

    task automatic wait_ack(input int id, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_lb);
            if ((id == 0) ? m0_ack : m1_ack) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    // n back-to-back beats; req stays high between beats (each is a new request).
    task automatic run_beats(input int id, input int n, input logic w,
                             input logic [31:0] a0, input logic [31:0] d0, input int slat);
        bit ok;
        @(posedge clk_lb); #1;
        for (int b = 0; b < n; b++) begin
            set_req(id, 1'b1, w, a0 + 32'(4 * b), d0 + 32'(b));
            push_exp(id, w, a0 + 32'(4 * b), d0 + 32'(b), slat);
            wait_ack(id, ok);
            @(posedge clk_lb); #1;
            if (!ok) break;
        end
        set_req(id, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_lb);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0_cnt;
        int a1_cnt;
        bit ok;

        // Reset values
        repeat (2) @(negedge clk_lb);
        chk("rst_m0_ack", m0_ack, 1'b0);
        chk("rst_m1_ack", m1_ack, 1'b0);
        chk("rst_m0_err", m0_err, 1'b0);
        chk("rst_m1_err", m1_err, 1'b0);
        chk("rst_lb_wr", lb_wr, 1'b0);
        chk("rst_lb_rd", lb_rd, 1'b0);
        chk("rst_lb_addr", lb_addr, 32'h0);
        chk("rst_lb_wr_d", lb_wr_d, 32'h0);
        chk("rst_m0_rd_d", m0_rd_d, 32'h0);
        chk("rst_m1_rd_d", m1_rd_d, 32'h0);
        @(posedge clk_lb); #1;
        reset_n = 1'b1;
        idle(2);

        // Simultaneous back-to-back writes: strict alternation, m0 first
        ack_log.delete();
        fork
            run_beats(0, 4, 1'b1, 32'h0000_1000, 32'hA000_0000, -1);
            run_beats(1, 4, 1'b1, 32'h0000_2000, 32'hB000_0000, -1);
        join
        chk("rr_count", ack_log.size(), 8);
        for (int i = 0; i < ack_log.size() && i < 8; i++)
            chk($sformatf("rr_grant%0d", i), ack_log[i], i % 2);
        idle(2);

        // Single write from m0
        a1_cnt = ack_cnt[1];
        run_beats(0, 1, 1'b1, 32'h0001_0010, 32'h1234_5678, 1);
        idle(5);
        chk("m1_no_ack", ack_cnt[1], a1_cnt);

        // m1 read, rdy 3 cycles after lb_rd
        fab_delay = 3; fab_data = 32'hCAFE_F00D;
        run_beats(1, 1, 1'b0, 32'h0002_0000, 32'h0, 1);
        idle(2);

        // m0 read timeout, then a stray rdy 2 cycles after the ack
        fab_delay = -1;
        a0_cnt = ack_cnt[0];
        run_beats(0, 1, 1'b0, 32'h0003_0000, 32'h0, 1);
        stray_at = cyc + 1;
        idle(4);
        chk("rd_d_after_stray", m0_rd_d, ERR_DATA);
        chk("no_ack_on_stray", ack_cnt[0], a0_cnt + 1);
        stray_at = -1;
        // A write must not disturb the held read data
        run_beats(0, 1, 1'b1, 32'h0003_0004, 32'h1111_2222, 1);
        idle(2);

        // rdy on the terminal count, just past it, and immediately
        fab_delay = RDT; fab_data = 32'h5A5A_0008;
        run_beats(0, 1, 1'b0, 32'h0005_0000, 32'h0, 1);
        fab_delay = RDT + 1; fab_data = 32'h5A5A_0009;
        run_beats(0, 1, 1'b0, 32'h0005_0004, 32'h0, 1);
        fab_delay = 0; fab_data = 32'h0BAD_0001;
        run_beats(1, 1, 1'b0, 32'h0005_0008, 32'h0, 1);
        idle(3);

        // Reset while waiting for read data, with m1 pending
        fab_delay = -1;
        @(posedge clk_lb); #1;
        set_req(0, 1'b1, 1'b0, 32'h0004_0000, 32'h0);
        repeat (3) @(posedge clk_lb);
        #1;
        set_req(1, 1'b1, 1'b1, 32'h0004_0100, 32'hABCD_0001);
        repeat (2) @(posedge clk_lb);
        @(negedge clk_lb);
        reset_n = 1'b0;
        #1;
        chk("arst_lb_rd", lb_rd, 1'b0);
        chk("arst_m0_ack", m0_ack, 1'b0);
        chk("arst_lb_addr", lb_addr, 32'h0);
        chk("arst_m0_rd_d", m0_rd_d, 32'h0);
        chk("arst_m1_rd_d", m1_rd_d, 32'h0);
        set_req(0, 1'b0, 1'b0, '0, '0);
        model_rd[0] = '0;
        model_rd[1] = '0;
        strobes = 0;
        a0_cnt = ack_cnt[0];
        repeat (2) @(posedge clk_lb);
        #1;
        reset_n = 1'b1;
        push_exp(1, 1'b1, 32'h0004_0100, 32'hABCD_0001, 1);
        wait_ack(1, ok);
        @(posedge clk_lb); #1;
        set_req(1, 1'b0, 1'b0, '0, '0);
        idle(RDT + 6);
        chk("no_stale_m0_ack", ack_cnt[0], a0_cnt);
        chk("sb0_empty", sb0.size(), 0);
        chk("sb1_empty", sb1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_lb_arbiter
